spi_arbiter: RTL and testbench

Shares the single SPI master among NREQ requesters, such as the host command path and an autonomous ADC/PLL init or monitor sequencer. Each requester posts a complete 1–4 byte transaction. The block then:
- arbitrates round-robin between requesters;
- drives chip select and MISO select with fixed setup/hold spacing;
- feeds bytes to the SPI master through its ready/valid pulse handshake;
- returns the last received byte to the winning requester.

It sits between the command processor and the SPI master, in the `clk` domain.

---
 rtl/spi_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_spi_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_arbiter.sv
// rtl/spi_arbiter.sv - round-robin arbiter sharing one SPI master among NREQ requesters
// Each grant runs one 1-4 byte transaction with CS setup/hold spacing and a DRAIN watchdog.
module spi_arbiter #(
    parameter int NREQ     = 2,
    parameter int CS_SETUP = 6,
    parameter int CS_HOLD  = 16,
    parameter int TIMEOUT  = 1024
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [3*NREQ-1:0]    req_cs,
    input  logic [3*NREQ-1:0]    req_nbytes,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 rsp_err,
    output logic [7:0]           spics,
    output logic [2:0]           spimisossel,
    output logic [7:0]           spitx,
    output logic                 spitxdv,
    input  logic                 spitxready,
    input  logic [7:0]           spirx,
    input  logic                 spirxdv,
    output logic                 busy
);

    localparam int PW    = (NREQ > 2) ? 2 : 1;
    localparam int CMAX0 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int CMAX  = (CMAX0 > TIMEOUT) ? CMAX0 : TIMEOUT;
    localparam int CW    = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_OFFER, S_SEND, S_DRAIN, S_HOLD, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [2:0]      cs_q, cs_d;
    logic [2:0]      nb_q, nb_d;
    logic [31:0]     data_q, data_d;
    logic [2:0]      txcnt_q, txcnt_d;
    logic [2:0]      rxcnt_q, rxcnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            any_req;
    logic            found;
    logic [PW:0]     cand;
    logic [PW-1:0]   gnt;
    logic [2:0]      sel_cs;
    logic [2:0]      sel_nb;
    logic [31:0]     sel_data;
    logic            cs_active;
    logic            rx_hit;
    logic            rx_last;
    logic            rx_done;

    function automatic logic [2:0] norm_nb(input logic [2:0] n);
        if (n == 3'd0) return 3'd1;
        if (n > 3'd4)  return 3'd4;
        return n;
    endfunction

    // First pending requester at or after ptr, wrapping in index order.
    always_comb begin
        any_req = |req_valid;
        found   = 1'b0;
        gnt     = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
            if (!found && req_valid[cand[PW-1:0]]) begin
                found = 1'b1;
                gnt   = cand[PW-1:0];
            end
        end
    end

    always_comb begin
        sel_cs   = '0;
        sel_nb   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == PW'(i)) begin
                sel_cs   = req_cs[3*i +: 3];
                sel_nb   = req_nbytes[3*i +: 3];
                sel_data = req_data[32*i +: 32];
            end
        end
    end

    assign cs_active = (state_q == S_SETUP) || (state_q == S_OFFER) || (state_q == S_SEND) ||
                       (state_q == S_DRAIN) || (state_q == S_HOLD);
    assign rx_hit  = spirxdv && (state_q == S_SETUP || state_q == S_OFFER ||
                                 state_q == S_SEND  || state_q == S_DRAIN);
    assign rx_last = rx_hit && ((rxcnt_q + 3'd1) == nb_q);
    // Including the in-flight pulse lets HOLD start the cycle after the final rx byte.
    assign rx_done = (rxcnt_q == nb_q) || rx_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cs_q    <= '0;
            nb_q    <= '0;
            data_q  <= '0;
            txcnt_q <= '0;
            rxcnt_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cs_q    <= cs_d;
            nb_q    <= nb_d;
            data_q  <= data_d;
            txcnt_q <= txcnt_d;
            rxcnt_q <= rxcnt_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cs_d    = cs_q;
        nb_d    = nb_q;
        data_d  = data_q;
        txcnt_d = txcnt_q;
        rxcnt_d = rxcnt_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        if (rx_hit && rxcnt_q != 3'd7) rxcnt_d = rxcnt_q + 3'd1;
        if (rx_last) rdata_d = spirx;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    cs_d    = sel_cs;
                    nb_d    = norm_nb(sel_nb);
                    data_d  = sel_data;
                    owner_d = gnt;
                    ptr_d   = (gnt == PW'(NREQ-1)) ? '0 : gnt + PW'(1);
                    txcnt_d = '0;
                    rxcnt_d = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(CS_SETUP-1)) begin
                    cnt_d   = '0;
                    state_d = S_OFFER;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OFFER: begin
                if (spitxready) begin
                    txcnt_d = txcnt_q + 3'd1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (txcnt_q < nb_q) begin
                    state_d = S_OFFER;
                end else begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rx_done) begin
                    cnt_d   = '0;
                    state_d = S_HOLD;
                end else if (cnt_q == CW'(TIMEOUT-1)) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    rdata_d = 8'hFF;
                    state_d = S_HOLD;
                end else if (cnt_q != CW'(CMAX)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == CW'(CS_HOLD-1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready   = '0;
        rsp_valid   = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = (state_q == S_IDLE) && any_req && (gnt == PW'(i));
            rsp_valid[i] = (state_q == S_DONE) && (owner_q == PW'(i));
        end
        spics       = cs_active ? ~(8'h01 << cs_q) : 8'hFF;
        spimisossel = cs_active ? cs_q : 3'd0;
        spitx       = (state_q == S_OFFER) ? data_q[{txcnt_q[1:0], 3'b000} +: 8] : 8'h00;
        spitxdv     = (state_q == S_OFFER) && spitxready;
        busy        = (state_q != S_IDLE);
        rsp_data    = rdata_q;
        rsp_err     = err_q;
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb/tb_spi_arbiter.sv - directed bench for spi_arbiter with an 8-cycle-per-byte model master
module tb_spi_arbiter;

    localparam int NREQ     = 2;
    localparam int CS_SETUP = 6;
    localparam int CS_HOLD  = 16;
    localparam int TIMEOUT  = 1024;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [3*NREQ-1:0]    req_cs;
    logic [3*NREQ-1:0]    req_nbytes;
    logic [32*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      rsp_valid;
    logic [7:0]           rsp_data;
    logic                 rsp_err;
    logic [7:0]           spics;
    logic [2:0]           spimisossel;
    logic [7:0]           spitx;
    logic                 spitxdv;
    logic                 spitxready;
    logic [7:0]           spirx;
    logic                 spirxdv;
    logic                 busy;

    always #5 clk = ~clk;

    spi_arbiter #(
        .NREQ(NREQ), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cs(req_cs), .req_nbytes(req_nbytes), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .spics(spics), .spimisossel(spimisossel),
        .spitx(spitx), .spitxdv(spitxdv), .spitxready(spitxready),
        .spirx(spirx), .spirxdv(spirxdv), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model master controls (written by the main process only)
    logic       stall = 1'b0;
    logic       drop_last = 1'b0;
    logic [7:0] rx_tab [4];
    int         rx_exp = 1;

    // Monitor state (written by the monitor only)
    logic       tx_hit;
    logic       prev_dv, prev_low;
    int         cur_low, cur_ntx, cur_setup, since_tx, since_rx;
    logic [7:0] cur_cs;
    logic [2:0] cur_sel;
    int         last_low, last_ntx, last_setup, last_hold, last_tx2cs;
    logic [7:0] last_cs;
    logic [2:0] last_sel;
    int         min_low = 32'h7fffffff;
    int         viol = 0;
    logic [7:0] tx_log [$];
    int         grant_log [$];

    // Model state (written by the model only)
    logic       hit;
    int         tmr, rx_idx;

    always begin
        @(posedge clk);
        hit = tx_hit;
        #1;
        spirxdv = 1'b0;
        if (!rstn) begin
            tmr = 0;
            rx_idx = 0;
            spitxready = !stall;
            spirx = 8'h00;
        end else begin
            if (spics == 8'hFF) rx_idx = 0;
            if (hit) begin
                spitxready = 1'b0;
                tmr = 7;
            end else if (tmr > 0) begin
                tmr--;
                if (tmr == 0) begin
                    if (!(drop_last && rx_idx == rx_exp - 1) && rx_idx < 4) begin
                        spirxdv = 1'b1;
                        spirx = rx_tab[rx_idx];
                    end
                    rx_idx++;
                    spitxready = !stall;
                end
            end else begin
                spitxready = !stall;
            end
        end
    end

    always @(negedge clk) begin
        if (!rstn) begin
            prev_dv = 1'b0; prev_low = 1'b0; tx_hit = 1'b0;
            cur_low = 0; cur_ntx = 0; cur_setup = 0; since_tx = 0; since_rx = 0;
        end else begin
            if (spitxdv && prev_dv) viol++;
            if (spitxdv && spics == 8'hFF) viol++;
            prev_dv = spitxdv;
            tx_hit = spitxdv;
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i]) grant_log.push_back(i);
            if (spics != 8'hFF) begin
                cur_low++;
                cur_cs = spics;
                cur_sel = spimisossel;
                if (spitxdv) begin
                    cur_ntx++;
                    tx_log.push_back(spitx);
                    if (cur_ntx == 1) cur_setup = cur_low - 1;
                    since_tx = 0;
                end else begin
                    since_tx++;
                end
                if (spirxdv) since_rx = 0; else since_rx++;
            end else if (prev_low) begin
                last_low = cur_low; last_ntx = cur_ntx; last_setup = cur_setup;
                last_hold = since_rx; last_tx2cs = since_tx;
                last_cs = cur_cs; last_sel = cur_sel;
                if (cur_low < min_low) min_low = cur_low;
                cur_low = 0; cur_ntx = 0; cur_setup = 0; since_tx = 0; since_rx = 0;
            end
            prev_low = (spics != 8'hFF);
        end
    end

    task automatic post(input int i, input logic [2:0] cs, input logic [2:0] nb, input logic [31:0] d);
        int t;
        @(posedge clk); #1;
        req_cs[3*i +: 3] = cs;
        req_nbytes[3*i +: 3] = nb;
        req_data[32*i +: 32] = d;
        req_valid[i] = 1'b1;
        t = 0;
        while (!req_ready[i] && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("grant", req_ready[i], 1'b1);
        chk("busy_at_grant", busy, 1'b0);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        chk("busy_after_grant", busy, 1'b1);
        chk("cs_low_after_grant", spics != 8'hFF, 1'b1);
    endtask

    task automatic wait_rsp(output int owner, output logic [7:0] d, output logic e);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (rsp_valid == '0 && t < 3000);
        chk("rsp_seen", rsp_valid != '0, 1'b1);
        owner = rsp_valid[1] ? 1 : 0;
        d = rsp_data;
        e = rsp_err;
        @(negedge clk);
        chk("rsp_one_cycle", rsp_valid, '0);
    endtask

    int         own, tb0, gb, seen, t;
    logic [7:0] rd;
    logic       re;
    int         owners [4];

    initial begin
        rstn = 1'b0;
        req_valid = '0; req_cs = '0; req_nbytes = '0; req_data = '0;
        rx_tab = '{8'h00, 8'h00, 8'h00, 8'h00};
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_rsp_valid", rsp_valid, '0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_spics", spics, 8'hFF);
        chk("rst_misosel", spimisossel, 3'd0);
        chk("rst_spitx", spitx, 8'h00);
        chk("rst_spitxdv", spitxdv, 1'b0);
        chk("rst_busy", busy, 1'b0);
        @(posedge clk); #1 rstn = 1'b1;
        repeat (2) @(negedge clk);

        // 2-byte write to chip 2
        rx_tab = '{8'h3C, 8'h5A, 8'h00, 8'h00}; rx_exp = 2;
        tb0 = tx_log.size();
        post(0, 3'd2, 3'd2, 32'h0000_0580);
        wait_rsp(own, rd, re);
        chk("wr_owner", own, 0);
        chk("wr_data", rd, 8'h5A);
        chk("wr_err", re, 1'b0);
        chk("wr_spics", last_cs, 8'b1111_1011);
        chk("wr_misosel", last_sel, 3'd2);
        chk("wr_ntx", last_ntx, 2);
        chk("wr_tx0", tx_log[tb0], 8'h80);
        chk("wr_tx1", tx_log[tb0+1], 8'h05);
        chk("wr_setup", last_setup, CS_SETUP);
        chk("wr_hold", last_hold, CS_HOLD);

        // 4-byte read from requester 1, chip 5
        rx_tab = '{8'h11, 8'h22, 8'h33, 8'hA5}; rx_exp = 4;
        tb0 = tx_log.size();
        post(1, 3'd5, 3'd4, 32'h4433_2211);
        wait_rsp(own, rd, re);
        chk("rd_owner", own, 1);
        chk("rd_data", rd, 8'hA5);
        chk("rd_err", re, 1'b0);
        chk("rd_ntx", last_ntx, 4);
        chk("rd_spics", last_cs, 8'b1101_1111);
        chk("rd_misosel", last_sel, 3'd5);
        chk("rd_tx3", tx_log[tb0+3], 8'h44);
        chk("rd_hold", last_hold, CS_HOLD);

        // Round-robin with both requesters held high
        rx_tab = '{8'h77, 8'h00, 8'h00, 8'h00}; rx_exp = 1;
        gb = grant_log.size();
        @(posedge clk); #1;
        req_cs = {3'd1, 3'd0}; req_nbytes = {3'd1, 3'd1};
        req_data = {32'h0000_00B1, 32'h0000_00B0};
        req_valid = 2'b11;
        seen = 0; t = 0;
        while (seen < 4 && t < 2000) begin
            @(negedge clk);
            t++;
            if (rsp_valid != '0) begin
                owners[seen] = rsp_valid[1] ? 1 : 0;
                seen++;
            end
        end
        req_valid = '0;
        repeat (3) @(negedge clk);
        chk("rr_rsp_count", seen, 4);
        chk("rr_grant_count", grant_log.size() - gb, 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr_grant%0d", k), grant_log[gb+k], k % 2);
            chk($sformatf("rr_owner%0d", k), owners[k], k % 2);
        end

        // nbytes normalisation
        rx_tab = '{8'h61, 8'h00, 8'h00, 8'h00}; rx_exp = 1;
        tb0 = tx_log.size();
        post(0, 3'd0, 3'd0, 32'h0000_00C3);
        wait_rsp(own, rd, re);
        chk("nb0_ntx", last_ntx, 1);
        chk("nb0_tx0", tx_log[tb0], 8'hC3);
        chk("nb0_data", rd, 8'h61);
        rx_tab = '{8'h01, 8'h02, 8'h03, 8'h9E}; rx_exp = 4;
        tb0 = tx_log.size();
        post(1, 3'd1, 3'd7, 32'hDDCC_BBAA);
        wait_rsp(own, rd, re);
        chk("nb7_ntx", last_ntx, 4);
        chk("nb7_tx3", tx_log[tb0+3], 8'hDD);
        chk("nb7_data", rd, 8'h9E);

        // Final rx byte dropped: watchdog timeout
        rx_tab = '{8'h55, 8'h00, 8'h00, 8'h00}; rx_exp = 1; drop_last = 1'b1;
        post(0, 3'd3, 3'd1, 32'h0000_005E);
        wait_rsp(own, rd, re);
        drop_last = 1'b0;
        chk("to_owner", own, 0);
        chk("to_err", re, 1'b1);
        chk("to_data", rd, 8'hFF);
        chk("to_tx_to_cs_high", last_tx2cs, 1 + TIMEOUT + CS_HOLD);

        // Reset while stalled in OFFER
        stall = 1'b1;
        repeat (2) @(negedge clk);
        post(0, 3'd4, 3'd2, 32'h0000_1234);
        repeat (CS_SETUP + 3) @(negedge clk);
        chk("offer_cs_low", spics, 8'b1110_1111);
        rstn = 1'b0;
        #1;
        chk("arst_spics", spics, 8'hFF);
        chk("arst_spitxdv", spitxdv, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_rsp_valid", rsp_valid, '0);
        stall = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_rsp_valid", rsp_valid, '0);
        rx_tab = '{8'h42, 8'h00, 8'h00, 8'h00}; rx_exp = 1;
        @(posedge clk); #1;
        req_cs = {3'd6, 3'd0}; req_nbytes = {3'd1, 3'd1};
        req_data = {32'h0000_0011, 32'h0000_0010};
        req_valid = 2'b11;
        t = 0;
        while (req_ready == '0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("post_rst_grant", req_ready, 2'b01);
        @(posedge clk); #1 req_valid = '0;
        wait_rsp(own, rd, re);
        chk("post_rst_owner", own, 0);
        chk("post_rst_data", rd, 8'h42);

        chk("txdv_violations", viol, 0);
        chk("min_cs_low_ok", min_low >= CS_SETUP + CS_HOLD, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
